// File: rtl/disassembler.sv
// disassembler: RX-side packet splitter. Captures the header from the low lanes
// of the first beat, checks its IPv4 checksum, and shifts the payload down so it
// starts at lane 0, using a one-beat carry register plus a trailing flush beat.
module disassembler #(
  parameter int phit_size    = 512,
  parameter int SIMD_degree  = 16,
  parameter int header_bytes = 36,
  parameter int header_deg   = header_bytes / 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [phit_size-1:0]      tdata_in,
  input  logic [SIMD_degree-1:0]    tvalid_in,
  input  logic [SIMD_degree-1:0]    tlast_in,
  output logic [header_bytes*8-1:0] header_out,
  output logic                      is_header_out,
  output logic                      csum_valid,
  output logic                      csum_ok,
  output logic [phit_size-1:0]      tdata_out,
  output logic [SIMD_degree-1:0]    tvalid_out,
  output logic [SIMD_degree-1:0]    tlast_out,
  output logic                      proto_err
);

  // Lanes left over above the header on the first beat; these form the carry.
  localparam int carry_deg = SIMD_degree - header_deg;
  localparam int carry_w   = carry_deg * 32;
  localparam int head_w    = header_deg * 32;
  // Bit offset of the IPv4 header inside the captured header.
  localparam int ip_base   = 112;

  typedef enum logic [1:0] {IDLE, PAYLOAD, FLUSH} state_t;

  state_t               state;
  logic [carry_w-1:0]   carry_data;
  logic [carry_deg-1:0] carry_valid;

  logic present;
  logic last;
  logic high_any;

  assign present  = |tvalid_in;
  assign last     = present & (|tlast_in);
  assign high_any = |tvalid_in[SIMD_degree-1:header_deg];

  // Packet FSM: header capture, payload re-alignment and flush, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      carry_data    <= '0;
      carry_valid   <= '0;
      header_out    <= '0;
      is_header_out <= 1'b0;
      tdata_out     <= '0;
      tvalid_out    <= '0;
      tlast_out     <= '0;
      proto_err     <= 1'b0;
    end else begin
      is_header_out <= 1'b0;
      proto_err     <= 1'b0;
      tdata_out     <= '0;
      tvalid_out    <= '0;
      tlast_out     <= '0;
      case (state)
        IDLE: begin
          if (present) begin
            header_out    <= tdata_in[head_w-1:0];
            is_header_out <= 1'b1;
            carry_data    <= tdata_in[phit_size-1:head_w];
            carry_valid   <= tvalid_in[SIMD_degree-1:header_deg];
            if (last) state <= high_any ? FLUSH : IDLE;
            else      state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (present) begin
            tdata_out   <= {tdata_in[head_w-1:0], carry_data};
            tvalid_out  <= {tvalid_in[header_deg-1:0], carry_valid};
            carry_data  <= tdata_in[phit_size-1:head_w];
            carry_valid <= tvalid_in[SIMD_degree-1:header_deg];
            if (last) begin
              if (high_any) begin
                state <= FLUSH;
              end else begin
                tlast_out <= '1;
                state     <= IDLE;
              end
            end
          end
        end
        FLUSH: begin
          // Any beat arriving here broke the inter-packet idle gap and is lost.
          tdata_out  <= {{head_w{1'b0}}, carry_data};
          tvalid_out <= {{header_deg{1'b0}}, carry_valid};
          tlast_out  <= '1;
          proto_err  <= present;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [19:0] s1 [5];
  logic [19:0] s2 [3];
  logic        v1;
  logic        v2;
  logic [19:0] total;
  logic [19:0] fold1;
  logic [15:0] fold2;

  // Final sum and end-around-carry folds feeding the result register.
  always_comb begin
    total = s2[0] + s2[1] + s2[2];
    fold1 = {4'b0, total[15:0]} + {16'b0, total[19:16]};
    fold2 = fold1[15:0] + {12'b0, fold1[19:16]};
  end

  // Three-stage checksum pipeline launched by each header capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) s1[i] <= '0;
      for (int i = 0; i < 3; i++) s2[i] <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      csum_valid <= 1'b0;
      csum_ok    <= 1'b0;
    end else begin
      v1 <= is_header_out;
      for (int i = 0; i < 5; i++)
        s1[i] <= 20'(header_out[ip_base + 32*i +: 16]) +
                 20'(header_out[ip_base + 16 + 32*i +: 16]);
      v2    <= v1;
      s2[0] <= s1[0] + s1[1];
      s2[1] <= s1[2] + s1[3];
      s2[2] <= s1[4];
      csum_valid <= v2;
      if (v2) csum_ok <= (fold2 == 16'hFFFF);
    end
  end

endmodule

// File: tb/tb_disassembler.sv
// tb_disassembler: schedule-driven bench. Packets are generated up front and
// the expected output of every cycle is derived from a flat lane-stream view of
// each packet, then compared against the DUT cycle by cycle.
module tb_disassembler;

  localparam int W  = 512;
  localparam int L  = 16;
  localparam int HD = 9;
  localparam int HW = 288;
  localparam int N  = 1600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W-1:0]  tdata_in;
  logic [L-1:0]  tvalid_in, tlast_in;
  logic [HW-1:0] header_out;
  logic          is_header_out, csum_valid, csum_ok, proto_err;
  logic [W-1:0]  tdata_out;
  logic [L-1:0]  tvalid_out, tlast_out;

  disassembler dut (
    .clk(clk), .rst(rst), .tdata_in(tdata_in), .tvalid_in(tvalid_in),
    .tlast_in(tlast_in), .header_out(header_out), .is_header_out(is_header_out),
    .csum_valid(csum_valid), .csum_ok(csum_ok), .tdata_out(tdata_out),
    .tvalid_out(tvalid_out), .tlast_out(tlast_out), .proto_err(proto_err)
  );

  // stimulus per cycle, expectations indexed by the edge that produced them
  logic [W-1:0]  in_data [N];
  logic [L-1:0]  in_valid[N], in_last[N];
  logic          in_rst  [N];
  logic [W-1:0]  e_data  [N];
  logic [L-1:0]  e_valid [N], e_last[N];
  logic          e_hdr_p [N], e_cv[N], e_ck[N], e_perr[N];
  logic [HW-1:0] e_hdr_v [N], e_hdr[N];

  int cur = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int c, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand512();
    logic [W-1:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [L-1:0] rand_nz();
    logic [L-1:0] v;
    v = L'($urandom);
    if (v == '0) v = 1;
    return v;
  endfunction

  // ones-complement sum of the ten IPv4 header words must be all-ones
  function automatic logic csum_good(input logic [HW-1:0] h);
    int s;
    s = 0;
    for (int k = 0; k < 10; k++) s += int'(h[112 + 16*k +: 16]);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return (s == 32'hFFFF);
  endfunction

  function automatic logic [HW-1:0] make_hdr(input logic good);
    logic [HW-1:0] h;
    int s;
    for (int i = 0; i < 9; i++) h[32*i +: 32] = $urandom;
    if (good) begin
      h[192 +: 16] = '0;
      s = 0;
      for (int k = 0; k < 10; k++) s += int'(h[112 + 16*k +: 16]);
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      h[192 +: 16] = ~s[15:0];
    end
    return h;
  endfunction

  task automatic put_beat(input logic [W-1:0] d, input logic [L-1:0] v, input logic [L-1:0] l);
    in_data[cur] = d; in_valid[cur] = v; in_last[cur] = l; in_rst[cur] = 1'b0;
    cur++;
  endtask

  task automatic put_idle();
    put_beat(rand512(), '0, L'($urandom));
  endtask

  task automatic do_reset();
    int r;
    r = cur;
    in_rst[r] = 1'b1; in_valid[r] = rand_nz(); in_last[r] = L'($urandom);
    e_data[r] = '0; e_valid[r] = '0; e_last[r] = '0; e_hdr_p[r] = 1'b0;
    e_cv[r] = 1'b0; e_ck[r] = 1'b0; e_perr[r] = 1'b0;
    e_cv[r+1] = 1'b0; e_ck[r+1] = 1'b0; e_cv[r+2] = 1'b0; e_ck[r+2] = 1'b0;
    cur++;
  endtask

  // v0/vmid/vlast of zero mean "random"; abort_after >= 0 resets after that beat
  task automatic gen_packet(input int n, input logic good, input logic flip,
                            input logic [L-1:0] v0, input logic [L-1:0] vmid,
                            input logic [L-1:0] vlast, input logic gaps,
                            input logic violate, input int abort_after,
                            output int c0, output int clast);
    logic [W-1:0]  bd[4];
    logic [L-1:0]  bv[4];
    int            cy[4];
    logic [31:0]   fl[$];
    logic          fv[$];
    logic [HW-1:0] h;
    logic          aborted;
    int            placed, nout, idx, p;
    aborted = 1'b0;
    placed  = 0;
    for (int k = 0; k < n; k++) begin
      bd[k] = rand512();
      if (k == n-1 && n > 1) bv[k] = (vlast != '0) ? vlast : rand_nz();
      else if (k == 0)       bv[k] = (v0 != '0) ? v0 : {7'($urandom), 9'h1FF};
      else                   bv[k] = (vmid != '0) ? vmid : rand_nz();
    end
    h = make_hdr(good);
    if (flip) h[120] = ~h[120];
    bd[0][HW-1:0] = h;
    for (int k = 0; k < n; k++) begin
      if (abort_after >= 0 && k == abort_after + 1) begin
        do_reset();
        aborted = 1'b1;
        break;
      end
      if (k > 0 && gaps) repeat ($urandom_range(0, 2)) put_idle();
      cy[k] = cur;
      put_beat(bd[k], bv[k], (k == n-1) ? rand_nz() : '0);
      placed++;
      if (k == 0) begin
        e_hdr_p[cy[0]] = 1'b1; e_hdr_v[cy[0]] = h;
        e_cv[cy[0]+3] = 1'b1;  e_ck[cy[0]+3] = csum_good(h);
      end
    end
    // payload as one continuous lane stream, cut into output beats of L lanes
    for (int i = HD; i < L; i++) begin fl.push_back(bd[0][32*i +: 32]); fv.push_back(bv[0][i]); end
    for (int k = 1; k < placed; k++)
      for (int i = 0; i < L; i++) begin fl.push_back(bd[k][32*i +: 32]); fv.push_back(bv[k][i]); end
    if (aborted) nout = placed - 1;
    else         nout = (n - 1) + ((|bv[n-1][L-1:HD]) ? 1 : 0);
    for (int j = 0; j < nout; j++) begin
      idx = (j + 1 < placed) ? cy[j+1] : cy[n-1] + 1;
      for (int i = 0; i < L; i++) begin
        p = L*j + i;
        if (p < fl.size()) begin
          e_data[idx][32*i +: 32] = fl[p];
          e_valid[idx][i] = fv[p];
        end
      end
      if (!aborted && j == nout - 1) e_last[idx] = '1;
    end
    c0 = cy[0];
    clast = cy[placed-1];
    if (!aborted && (|bv[n-1][L-1:HD])) begin
      if (violate) begin
        e_perr[cur] = 1'b1;
        put_beat(rand512(), rand_nz(), L'($urandom));
      end else begin
        put_idle();
      end
    end
  endtask

  initial begin
    int p1c0, p1cl, p2c0, p2cl, p3c0, p3cl, p4c0, p4cl, p5c0, p5cl, tc0, tcl;
    int n, ab;
    logic [HW-1:0] held, hx;

    for (int c = 0; c < N; c++) begin
      in_data[c] = rand512(); in_valid[c] = '0; in_last[c] = L'($urandom); in_rst[c] = 1'b0;
      e_data[c] = '0; e_valid[c] = '0; e_last[c] = '0; e_hdr_p[c] = 1'b0; e_hdr_v[c] = '0;
      e_cv[c] = 1'b0; e_ck[c] = 1'b0; e_perr[c] = 1'b0;
    end

    do_reset(); do_reset();
    put_idle();
    gen_packet(3, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, -1, p1c0, p1cl);
    put_idle(); put_idle();
    gen_packet(3, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h01FF, 1'b0, 1'b0, -1, p2c0, p2cl);
    put_idle();
    gen_packet(1, 1'b1, 1'b0, 16'h01FF, 16'h0, 16'h0, 1'b0, 1'b0, -1, p3c0, p3cl);
    put_idle();
    gen_packet(1, 1'b1, 1'b1, 16'h01FF, 16'h0, 16'h0, 1'b0, 1'b0, -1, p4c0, p4cl);
    put_idle();
    gen_packet(2, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, -1, p5c0, p5cl);
    put_idle();
    gen_packet(4, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1, tc0, tcl);
    gen_packet(3, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, -1, tc0, tcl);

    while (cur < N - 30) begin
      repeat ($urandom_range(0, 3)) put_idle();
      n = int'($urandom_range(1, 4));
      ab = -1;
      if (n >= 2 && $urandom_range(0, 11) == 0) ab = int'($urandom_range(0, n - 2));
      gen_packet(n, 1'($urandom_range(0, 1)), 1'b0, '0, '0, '0, 1'b1,
                 ($urandom_range(0, 7) == 0), ab, tc0, tcl);
    end

    held = '0;
    for (int c = 0; c < N; c++) begin
      if (in_rst[c])       held = '0;
      else if (e_hdr_p[c]) held = e_hdr_v[c];
      e_hdr[c] = held;
    end

    // hand-computed expectations pinning the model
    hx = '0; hx[192 +: 16] = 16'hFFFF;
    chk("pin_csum_allones", 0, W'(csum_good(hx)), W'(1'b1));
    hx = '0; hx[112 +: 16] = 16'h0001;
    chk("pin_csum_one", 0, W'(csum_good(hx)), W'(1'b0));
    chk("pin_p1_lane0", p1c0 + 1, W'(e_data[p1c0+1][31:0]), W'(in_data[p1c0][9*32 +: 32]));
    chk("pin_p1_full", p1c0 + 1, W'(e_valid[p1c0+1]), W'(16'hFFFF));
    chk("pin_p1_flush_valid", p1cl + 1, W'(e_valid[p1cl+1]), W'(16'h007F));
    chk("pin_p1_flush_last", p1cl + 1, W'(e_last[p1cl+1]), W'(16'hFFFF));
    chk("pin_p1_csum", p1c0 + 3, W'(e_ck[p1c0+3]), W'(1'b1));
    chk("pin_p2_last_valid", p2cl, W'(e_valid[p2cl]), W'(16'hFFFF));
    chk("pin_p2_last_last", p2cl, W'(e_last[p2cl]), W'(16'hFFFF));
    chk("pin_p2_no_flush", p2cl + 1, W'(e_valid[p2cl+1]), W'(16'h0000));
    chk("pin_p3_hdr_only", p3c0 + 1, W'(e_valid[p3c0+1]), W'(16'h0000));
    chk("pin_p4_csum_bad", p4c0 + 3, W'(e_ck[p4c0+3]), W'(1'b0));
    chk("pin_p5_perr", p5cl + 1, W'(e_perr[p5cl+1]), W'(1'b1));
    chk("pin_p5_no_hdr", p5cl + 1, W'(e_hdr_p[p5cl+1]), W'(1'b0));

    for (int c = 0; c < N; c++) begin
      rst = in_rst[c]; tdata_in = in_data[c]; tvalid_in = in_valid[c]; tlast_in = in_last[c];
      @(posedge clk);
      #1;
      chk("tdata_out", c, tdata_out, e_data[c]);
      chk("tvalid_out", c, W'(tvalid_out), W'(e_valid[c]));
      chk("tlast_out", c, W'(tlast_out), W'(e_last[c]));
      chk("is_header_out", c, W'(is_header_out), W'(e_hdr_p[c]));
      chk("header_out", c, W'(header_out), W'(e_hdr[c]));
      chk("csum_valid", c, W'(csum_valid), W'(e_cv[c]));
      chk("proto_err", c, W'(proto_err), W'(e_perr[c]));
      if (e_cv[c] || in_rst[c]) chk("csum_ok", c, W'(csum_ok), W'(e_ck[c]));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
